// File: rtl/beamformer_pkg.sv
// Shared constants and types for the delay-and-sum beamformer stage.
// Channel samples are signed; the beam sum has two guard bits so a 3-channel add never overflows.
package beamformer_pkg;
  localparam int CH_W  = 32;
  localparam int NCH   = 3;
  localparam int DEPTH = 16;
  localparam int DLY_W = 4;

  typedef logic signed [CH_W-1:0] sample_t;
  typedef logic signed [CH_W+1:0] beam_t;

  typedef enum logic {
    PRIMING = 1'b0,
    RUN     = 1'b1
  } state_t;
endpackage

// File: rtl/sample_ring.sv
// Circular sample history: one write port for the whole channel set, one read port per channel.
// A zero delay bypasses the array so the sample being written this cycle is used directly.
module sample_ring
  import beamformer_pkg::*;
(
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [DLY_W-1:0]       wr_ptr,
  input  logic [NCH*CH_W-1:0]    wr_data,
  input  logic [NCH*DLY_W-1:0]   rd_dly,
  output logic [NCH*CH_W-1:0]    rd_data
);
  logic [NCH*CH_W-1:0] mem [DEPTH];

  // History is never cleared; the caller's fill gating keeps stale entries out of the sum.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_rd
      logic [DLY_W-1:0] dly;
      logic [DLY_W-1:0] rd_addr;
      assign dly     = rd_dly[gi*DLY_W +: DLY_W];
      assign rd_addr = wr_ptr - dly;
      assign rd_data[gi*CH_W +: CH_W] = (dly == '0) ? wr_data[gi*CH_W +: CH_W]
                                                    : mem[rd_addr][gi*CH_W +: CH_W];
    end
  endgenerate
endmodule

// File: rtl/delay_sum_beamformer.sv
// Delays each filtered channel by a programmable sample count and sums the aligned channels.
// Output is held off until enough samples have been written since reset or the last cfg_load.
module delay_sum_beamformer
  import beamformer_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [NCH*CH_W-1:0]      in_data,
  input  logic                     cfg_load,
  input  logic [NCH*DLY_W-1:0]     delay_cfg,
  output logic                     out_valid,
  output logic signed [CH_W+1:0]   out_data,
  output logic                     primed
);
  state_t                state_reg, state_next;
  logic [DLY_W-1:0]      wr_ptr_reg;
  logic [DLY_W:0]        fill_reg, fill_next;
  logic [NCH*DLY_W-1:0]  dly_reg, dly_eff;
  logic [DLY_W-1:0]      dmax;
  logic [NCH*CH_W-1:0]   rd_data;
  beam_t                 sum;
  logic                  fire;

  // A load applies to the sample arriving in the same cycle.
  assign dly_eff = cfg_load ? delay_cfg : dly_reg;

  always_comb begin
    dmax = '0;
    for (int k = 0; k < NCH; k++) begin
      if (dly_eff[k*DLY_W +: DLY_W] > dmax) dmax = dly_eff[k*DLY_W +: DLY_W];
    end
  end

  always_comb begin
    fill_next = cfg_load ? '0 : fill_reg;
    if (in_valid && fill_next != (DLY_W+1)'(DEPTH)) fill_next = fill_next + (DLY_W+1)'(1);
  end

  assign fire = in_valid && (fill_next > {1'b0, dmax});

  sample_ring u_ring (
    .clk     (clk),
    .wr_en   (in_valid),
    .wr_ptr  (wr_ptr_reg),
    .wr_data (in_data),
    .rd_dly  (dly_eff),
    .rd_data (rd_data)
  );

  always_comb begin
    sum = '0;
    for (int k = 0; k < NCH; k++) begin
      sum = sum + {{2{rd_data[k*CH_W + CH_W - 1]}}, rd_data[k*CH_W +: CH_W]};
    end
  end

  always_comb begin
    state_next = state_reg;
    if (cfg_load) state_next = PRIMING;
    if (fire)     state_next = RUN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= PRIMING;
      wr_ptr_reg <= '0;
      fill_reg   <= '0;
      dly_reg    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      state_reg <= state_next;
      fill_reg  <= fill_next;
      out_valid <= fire;
      if (in_valid) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (cfg_load) dly_reg <= delay_cfg;
      if (fire)     out_data <= sum;
    end
  end

  assign primed = (state_reg == RUN);
endmodule

// File: tb/tb_delay_sum_beamformer.sv
// Directed bench for delay_sum_beamformer: a sample-history model pushes expected beam sums
// into a scoreboard queue that is popped whenever the DUT strobes out_valid.
module tb_delay_sum_beamformer;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [95:0]  in_data;
  logic         cfg_load;
  logic [11:0]  delay_cfg;
  logic         out_valid;
  logic [33:0]  out_data;
  logic         primed;

  int n_checks = 0;
  int n_fail   = 0;

  logic [95:0] hist[$];
  logic [33:0] sbq[$];
  logic [11:0] m_dly;
  int          m_cnt;
  logic        m_run;
  logic [33:0] m_out;

  always #5 clk = ~clk;

  delay_sum_beamformer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .cfg_load  (cfg_load),
    .delay_cfg (delay_cfg),
    .out_valid (out_valid),
    .out_data  (out_data),
    .primed    (primed)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] model_sum();
    logic signed [33:0] acc;
    logic signed [31:0] s;
    int d;
    acc = '0;
    for (int k = 0; k < 3; k++) begin
      d = int'(m_dly[k*4 +: 4]);
      s = hist[hist.size() - 1 - d][k*32 +: 32];
      acc = acc + s;
    end
    return acc;
  endfunction

  function automatic int model_dmax();
    int m;
    m = 0;
    for (int k = 0; k < 3; k++) if (int'(m_dly[k*4 +: 4]) > m) m = int'(m_dly[k*4 +: 4]);
    return m;
  endfunction

  task automatic model_reset();
    hist.delete();
    sbq.delete();
    m_dly = '0;
    m_cnt = 0;
    m_run = 1'b0;
    m_out = '0;
  endtask

  // One clock of stimulus; checks the DUT response one cycle later.
  task automatic send(input logic v, input logic [95:0] d, input logic ld, input logic [11:0] cfg);
    logic        exp_fire;
    logic [33:0] exp;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    cfg_load  = ld;
    delay_cfg = cfg;
    if (ld) begin
      m_dly = cfg;
      m_cnt = 0;
    end
    exp_fire = 1'b0;
    if (v) begin
      hist.push_back(d);
      m_cnt++;
      if (m_cnt > model_dmax()) begin
        exp_fire = 1'b1;
        sbq.push_back(model_sum());
      end
    end
    if (exp_fire) m_run = 1'b1;
    else if (ld)  m_run = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_load = 1'b0;
    chk("out_valid", 64'(out_valid), 64'(exp_fire));
    chk("primed", 64'(primed), 64'(m_run));
    if (exp_fire) begin
      exp   = sbq.pop_front();
      m_out = exp;
    end
    chk("out_data", 64'(out_data), 64'(m_out));
    $display("t=%0t v=%0b ld=%0b cfg=%h data=%h -> out_valid=%0b out_data=%h primed=%0b",
             $time, v, ld, cfg, d, out_valid, out_data, primed);
  endtask

  function automatic logic [95:0] rep3(input logic [31:0] x);
    return {x, x, x};
  endfunction

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    cfg_load = 1'b0;
    delay_cfg = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_primed", 64'(primed), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Zero delays: first sample emerges immediately.
    send(1'b1, {32'd3, 32'd2, 32'd1}, 1'b0, 12'h000);
    chk("first_sum", 64'(out_data), 64'd6);
    send(1'b0, '0, 1'b0, 12'h000);

    // Delays {0,1,2}: outputs 3n-3 starting at n=3.
    send(1'b0, '0, 1'b1, {4'd2, 4'd1, 4'd0});
    for (int n = 1; n <= 6; n++) begin
      send(1'b1, rep3(32'(n)), 1'b0, 12'h000);
      if (n >= 3) chk("stair_sum", 64'(out_data), 64'(3*n - 3));
    end

    // Signed extremes with zero delays.
    send(1'b1, rep3(32'h7FFFFFFF), 1'b1, 12'h000);
    chk("max_pos", 64'(out_data), 64'h17FFFFFFD);
    send(1'b1, rep3(32'h80000000), 1'b0, 12'h000);
    chk("max_neg", 64'(out_data), 64'h280000000);

    // Maximum delay on channel 0 across several pointer wraps; delay_cfg noise without a load is ignored.
    send(1'b0, '0, 1'b1, {4'd0, 4'd0, 4'd15});
    for (int n = 1; n <= 40; n++) begin
      send(1'b1, {$urandom(), $urandom(), $urandom()}, 1'b0, 12'($urandom()));
      if (n == 15) chk("d15_not_primed", 64'(primed), 64'd0);
      if (n == 16) chk("d15_first_out", 64'(out_valid), 64'd1);
    end

    // Reload mid-run together with a sample: output resumes on the third sample.
    send(1'b1, {$urandom(), $urandom(), $urandom()}, 1'b1, {4'd0, 4'd0, 4'd2});
    chk("reload_primed_drop", 64'(primed), 64'd0);
    for (int n = 2; n <= 6; n++) begin
      send(1'b1, {$urandom(), $urandom(), $urandom()}, 1'b0, 12'h000);
      if (n == 3) chk("reload_resume", 64'(out_valid), 64'd1);
    end

    // Asynchronous reset pulsed between edges.
    send(1'b1, {32'd100, 32'd200, 32'd300}, 1'b0, 12'h000);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_out_data", 64'(out_data), 64'd0);
    chk("async_primed", 64'(primed), 64'd0);
    #1 rst = 1'b1;
    model_reset();
    send(1'b0, '0, 1'b1, {4'd2, 4'd1, 4'd0});
    for (int n = 1; n <= 5; n++) begin
      send(1'b1, rep3(32'(n * 7)), 1'b0, 12'h000);
      if (n == 2) chk("post_rst_gated", 64'(out_valid), 64'd0);
    end

    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
